cp0_exception_unit: RTL and testbench
=====================================

CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

Interface
REQ-001 Parameter EXC_VECTOR, 32'h0000_0008, exception handler entry PC.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid  input  1  EX-stage holds a valid instruction.
REQ-005 ex_pc  input  32  PC of the EX-stage instruction.
REQ-006 ex_overflow  input  1  ALU signed-overflow flag (ADD/SUB/ADDI) for the EX instruction.
REQ-007 ex_eret  input  1  EX instruction is ERET.
REQ-008 ext_int  input  6  external interrupt request lines, level-sensitive.
REQ-009 cp0_we  input  1  MTC0 write strobe.
REQ-010 cp0_waddr  input  5  MTC0 target register number.
REQ-011 cp0_wdata  input  32  MTC0 write data.
REQ-012 cp0_raddr  input  5  MFC0 source register number.
REQ-013 cp0_rdata  output  32  MFC0 read data, combinational from current register state.
REQ-014 flush  output  1  one-cycle pipeline flush pulse.
REQ-015 redirect_valid  output  1  fetch redirect request.
REQ-016 redirect_pc  output  32  redirect target; stable while redirect_valid=1.
REQ-017 redirect_ack  input  1  fetch accepted the redirect this cycle.
REQ-018 in_handler  output  1  mirrors Status.EXL.

Function
REQ-019 Registers: Status(12): bit0 IE, bit1 EXL, bits15:10 IM, others read 0; Cause(13): bits6:2 ExcCode, bits15:10 IP, others 0; EPC(14): 32 bits; any other cp0_raddr reads 32'h0.
REQ-020 Cause.IP shall register ext_int every cycle.
REQ-021 States: IDLE, REDIRECT; events are evaluated only in IDLE.
REQ-022 Event priority in IDLE with ex_valid=1: overflow > interrupt (IE=1, EXL=0, |(ext_int & IM)) > ERET (ex_eret=1, EXL=1); ERET with EXL=0 is ignored.
REQ-023 Overflow: ExcCode<=12, EXL<=1, EPC<=ex_pc only if EXL was 0, redirect_pc<=EXC_VECTOR, state->REDIRECT.
REQ-024 Interrupt: ExcCode<=0, EXL<=1, EPC<=ex_pc, redirect_pc<=EXC_VECTOR, state->REDIRECT.
REQ-025 ERET: EXL<=0, redirect_pc<=EPC, state->REDIRECT.
REQ-026 flush=1 for exactly the first cycle in REDIRECT; redirect_valid=1 from that cycle until the cycle redirect_ack=1 inclusive; then state->IDLE.
REQ-027 redirect_ack=1 on the first REDIRECT cycle completes the handshake that cycle (1-cycle REDIRECT minimum).
REQ-028 MTC0 applies when cp0_we=1 and no event is taken that cycle; writes to Cause affect no field (IP, ExcCode read-only); unimplemented bits ignored.
REQ-029 MTC0 coincident with a taken event is dropped in full.
REQ-030 ex_valid=0 suppresses all events, including pending interrupts.

Reset
REQ-031 rst_n=0 shall immediately clear Status, Cause, EPC, redirect_pc to 0, state to IDLE, flush/redirect_valid/in_handler to 0, independent of clk.
REQ-032 Reset asserted in REDIRECT aborts the redirect; no flush or redirect follows deassertion.

Structure
REQ-033 Package cp0_pkg shall hold register numbers (12/13/14), ExcCode constants (INT=0, OV=12), Status/Cause bit positions and the state enum.
REQ-034 One sub-module, cp0_regfile, shall hold Status/Cause/EPC with read mux; the FSM stays in cp0_exception_unit.

Verification
REQ-035 ex_valid=1, ex_overflow=1, ex_pc=32'h0000_0040 -> next cycle flush=1, redirect_pc=32'h0000_0008, EPC=32'h40, Cause[6:2]=12, in_handler=1.
REQ-036 MTC0 Status=32'h0000_0401, ext_int=6'b000001, ex_valid=1, ex_pc=32'h80 -> interrupt taken, EPC=32'h80, ExcCode=0; same with IE=0 -> no event.
REQ-037 EXL=1, EPC=32'h40, ex_eret=1 -> redirect_pc=32'h40, in_handler=0; ERET with EXL=0 -> no flush.
REQ-038 redirect_ack held 0 for 3 cycles after exception -> redirect_valid high 4 cycles, flush high only first; new overflow during that window ignored.
REQ-039 Overflow with EXL=1, ex_pc=32'h100 -> EPC unchanged, ExcCode=12, redirect taken; cp0_we same cycle to EPC -> dropped.
REQ-040 rst_n low mid-REDIRECT (between edges) -> outputs 0 immediately, IDLE after release, no redirect.

Source files
------------

// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
//   Shared definitions for the CP0 exception unit: coprocessor-0 register
//   numbers, exception codes, Status/Cause field positions, the redirect FSM
//   state type and the decoded event type.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package cp0_pkg;

   // CP0 register numbers as seen by MTC0/MFC0
   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_OV  = 5'd12;

   // Status field positions
   localparam int STATUS_IE     = 0;
   localparam int STATUS_EXL    = 1;
   localparam int STATUS_IM_LSB = 10;
   localparam int STATUS_IM_MSB = 15;

   // Cause field positions
   localparam int CAUSE_EXC_LSB = 2;
   localparam int CAUSE_EXC_MSB = 6;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_IP_MSB  = 15;

   typedef enum logic {
      ST_IDLE,
      ST_REDIRECT
   } cp0_state_e;

   // Event selected for the EX instruction in the current cycle
   typedef enum logic [1:0] {
      EV_NONE,
      EV_OVERFLOW,
      EV_INTERRUPT,
      EV_ERET
   } cp0_event_e;

endpackage

// File: rtl/cp0_exception_unit_if.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit_if
//   Bundles the pipeline-facing signals of the CP0 exception unit.
//   slave  : the CP0 unit (consumes EX/MTC0/ack, drives read data/flush/redirect)
//   master : the pipeline / testbench side
//   Signals: ex_valid, ex_pc, ex_overflow, ex_eret, ext_int, cp0_we, cp0_waddr,
//            cp0_wdata, cp0_raddr, cp0_rdata, flush, redirect_valid,
//            redirect_pc, redirect_ack, in_handler.
// -----------------------------------------------------------------------------
interface cp0_exception_unit_if;

   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_overflow;
   logic        ex_eret;
   logic [5:0]  ext_int;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ack;
   logic        in_handler;

   modport slave (
      input  ex_valid, ex_pc, ex_overflow, ex_eret, ext_int,
      input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, redirect_ack,
      output cp0_rdata, flush, redirect_valid, redirect_pc, in_handler
   );

   modport master (
      output ex_valid, ex_pc, ex_overflow, ex_eret, ext_int,
      output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, redirect_ack,
      input  cp0_rdata, flush, redirect_valid, redirect_pc, in_handler
   );

endinterface

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
//   Holds Status (IE, EXL, IM), Cause (ExcCode, IP) and EPC, applies exception
//   entry / ERET / MTC0 updates and provides the MFC0 read mux.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     ext_int         interrupt lines, sampled into Cause.IP every cycle
//     exc_take        exception entry: set EXL, load ExcCode
//     exc_code        ExcCode to record on exception entry
//     epc_load        load EPC with epc_value (only meaningful with exc_take)
//     epc_value       PC of the faulting instruction
//     eret_take       ERET: clear EXL
//     mtc0_we/addr/data  software register write (already gated by caller)
//     raddr / rdata   MFC0 read port, combinational
//     status_ie/exl/im, epc   current register state for the control FSM
// -----------------------------------------------------------------------------
module cp0_regfile
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  ext_int,
   input  logic        exc_take,
   input  logic [4:0]  exc_code,
   input  logic        epc_load,
   input  logic [31:0] epc_value,
   input  logic        eret_take,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_data,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   output logic        status_ie,
   output logic        status_exl,
   output logic [5:0]  status_im,
   output logic [31:0] epc
);

   logic [4:0] cause_exc;
   logic [5:0] cause_ip;

   // Write-data bits with no Status storage are collected here and dropped
   logic unused_wdata_bits;
   assign unused_wdata_bits = ^{mtc0_data[31:STATUS_IM_MSB+1],
                                mtc0_data[STATUS_IM_LSB-1:STATUS_EXL+1]};

   // NOTE: sequential state is written only with non-blocking (<=) assignments
   // so every register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_ie  <= 1'b0;
         status_exl <= 1'b0;
         status_im  <= '0;
         cause_exc  <= '0;
         cause_ip   <= '0;
         epc        <= '0;
      end else begin
         cause_ip <= ext_int;
         if (exc_take) begin
            status_exl <= 1'b1;
            cause_exc  <= exc_code;
            if (epc_load) epc <= epc_value;
         end else if (eret_take) begin
            status_exl <= 1'b0;
         end else if (mtc0_we) begin
            // Cause is read-only from software; writes to it fall to default
            case (mtc0_addr)
               REG_STATUS: begin
                  status_ie  <= mtc0_data[STATUS_IE];
                  status_exl <= mtc0_data[STATUS_EXL];
                  status_im  <= mtc0_data[STATUS_IM_MSB:STATUS_IM_LSB];
               end
               REG_EPC:    epc <= mtc0_data;
               default:    ;
            endcase
         end
      end
   end

   // NOTE: every combinational output gets a default first so no path through
   // the case leaves it unassigned (which would infer a latch).
   always_comb begin
      rdata = '0;
      case (raddr)
         REG_STATUS: begin
            rdata[STATUS_IE]                   = status_ie;
            rdata[STATUS_EXL]                  = status_exl;
            rdata[STATUS_IM_MSB:STATUS_IM_LSB] = status_im;
         end
         REG_CAUSE: begin
            rdata[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc;
            rdata[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip;
         end
         REG_EPC:    rdata = epc;
         default:    rdata = '0;
      endcase
   end

endmodule

// File: rtl/cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit
//   Detects overflow exceptions, masked external interrupts and ERET for the
//   EX-stage instruction, updates CP0 state and issues a one-cycle flush plus a
//   fetch redirect held until the fetch stage acknowledges it.
//   Parameter: EXC_VECTOR  exception handler entry PC
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     bus         cp0_exception_unit_if.slave (EX info, MTC0/MFC0, flush,
//                 redirect handshake, in_handler)
// -----------------------------------------------------------------------------
module cp0_exception_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cp0_exception_unit_if.slave     bus
);

   cp0_state_e  state;
   cp0_event_e  ev;
   logic        flush_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;

   logic        status_ie;
   logic        status_exl;
   logic [5:0]  status_im;
   logic [31:0] epc;

   // Events are only recognised while no redirect is outstanding; priority is
   // overflow, then enabled interrupt, then ERET (which needs EXL set).
   always_comb begin
      ev = EV_NONE;
      if (state == ST_IDLE && bus.ex_valid) begin
         if (bus.ex_overflow)
            ev = EV_OVERFLOW;
         else if (status_ie && !status_exl && |(bus.ext_int & status_im))
            ev = EV_INTERRUPT;
         else if (bus.ex_eret && status_exl)
            ev = EV_ERET;
      end
   end

   logic       exc_take;
   logic [4:0] exc_code;
   logic       epc_load;
   logic       eret_take;
   logic       mtc0_we;

   assign exc_take  = (ev == EV_OVERFLOW) || (ev == EV_INTERRUPT);
   assign exc_code  = (ev == EV_OVERFLOW) ? EXC_OV : EXC_INT;
   // A nested overflow inside the handler keeps the original return address
   assign epc_load  = (ev == EV_INTERRUPT) || (ev == EV_OVERFLOW && !status_exl);
   assign eret_take = (ev == EV_ERET);
   // An MTC0 that coincides with a taken event is discarded entirely
   assign mtc0_we   = bus.cp0_we && (ev == EV_NONE);

   cp0_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .ext_int    (bus.ext_int),
      .exc_take   (exc_take),
      .exc_code   (exc_code),
      .epc_load   (epc_load),
      .epc_value  (bus.ex_pc),
      .eret_take  (eret_take),
      .mtc0_we    (mtc0_we),
      .mtc0_addr  (bus.cp0_waddr),
      .mtc0_data  (bus.cp0_wdata),
      .raddr      (bus.cp0_raddr),
      .rdata      (bus.cp0_rdata),
      .status_ie  (status_ie),
      .status_exl (status_exl),
      .status_im  (status_im),
      .epc        (epc)
   );

   // Redirect FSM with registered outputs. flush is high only in the first
   // REDIRECT cycle; redirect_valid holds until the cycle redirect_ack is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ev != EV_NONE) begin
                  state            <= ST_REDIRECT;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= (ev == EV_ERET) ? epc : EXC_VECTOR;
               end
            end
            ST_REDIRECT: begin
               flush_q <= 1'b0;
               if (bus.redirect_ack) begin
                  redirect_valid_q <= 1'b0;
                  state            <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.flush          = flush_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.in_handler     = status_exl;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exception_unit
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model of the CP0 rules kept in the bench.
// -----------------------------------------------------------------------------
module tb_cp0_exception_unit;
   import cp0_pkg::*;

   localparam logic [31:0] VEC = 32'h0000_0008;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cp0_exception_unit_if bus ();

   cp0_exception_unit #(.EXC_VECTOR(VEC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model: architectural register contents plus the age of the
   // outstanding redirect (0 = none, 1 = first cycle after the event, ...).
   logic        m_ie, m_exl;
   logic [5:0]  m_im, m_ip;
   logic [4:0]  m_exc;
   logic [31:0] m_epc, m_rpc;
   int          m_age;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] addr);
      case (addr)
         5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
         5'd13:   return {16'b0, m_ip, 3'b0, m_exc, 2'b0};
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_exc = '0;
      m_epc = '0; m_rpc = '0; m_age = 0;
   endtask

   task automatic check_outputs(input string sfx);
      check({"flush", sfx},          {31'b0, bus.flush},          {31'b0, m_age == 1});
      check({"redirect_valid", sfx}, {31'b0, bus.redirect_valid}, {31'b0, m_age != 0});
      check({"redirect_pc", sfx},    bus.redirect_pc,             m_rpc);
      check({"in_handler", sfx},     {31'b0, bus.in_handler},     {31'b0, m_exl});
      check({"rdata", sfx},          bus.cp0_rdata,               model_read(bus.cp0_raddr));
   endtask

   task automatic check_regs();
      logic [4:0] addrs [4];
      addrs = '{5'd12, 5'd13, 5'd14, 5'd3};
      for (int i = 0; i < 4; i++) begin
         bus.cp0_raddr = addrs[i];
         #1;
         check($sformatf("reg%0d", addrs[i]), bus.cp0_rdata, model_read(addrs[i]));
      end
   endtask

   task automatic check_reg_const(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      bus.cp0_raddr = addr;
      #1;
      check(tag, bus.cp0_rdata, exp);
   endtask

   // Predict the effect of the coming clock edge from current inputs, then
   // advance one cycle and compare.
   task automatic tick();
      logic        ie, exl;
      logic [5:0]  im, ip;
      logic [4:0]  exc;
      logic [31:0] epc, rpc;
      int          age;
      bit          taken;
      ie = m_ie; exl = m_exl; im = m_im; exc = m_exc;
      epc = m_epc; rpc = m_rpc; age = m_age;
      taken = 0;
      ip = bus.ext_int;
      if (age == 0 && bus.ex_valid) begin
         if (bus.ex_overflow) begin
            if (!exl) epc = bus.ex_pc;
            exl = 1; exc = 5'd12; rpc = VEC; taken = 1;
         end else if (ie && !exl && (bus.ext_int & im) != 6'd0) begin
            epc = bus.ex_pc; exl = 1; exc = 5'd0; rpc = VEC; taken = 1;
         end else if (bus.ex_eret && exl) begin
            exl = 0; rpc = epc; taken = 1;
         end
      end
      if (taken)         age = 1;
      else if (age != 0) age = bus.redirect_ack ? 0 : age + 1;
      if (bus.cp0_we && !taken) begin
         if (bus.cp0_waddr == 5'd12) begin
            ie = bus.cp0_wdata[0]; exl = bus.cp0_wdata[1]; im = bus.cp0_wdata[15:10];
         end else if (bus.cp0_waddr == 5'd14) begin
            epc = bus.cp0_wdata;
         end
      end
      @(posedge clk);
      #1;
      m_ie = ie; m_exl = exl; m_im = im; m_ip = ip; m_exc = exc;
      m_epc = epc; m_rpc = rpc; m_age = age;
      check_outputs("");
   endtask

   task automatic idle_inputs();
      bus.ex_valid = 0; bus.ex_pc = '0; bus.ex_overflow = 0; bus.ex_eret = 0;
      bus.ext_int = '0; bus.cp0_we = 0; bus.cp0_waddr = '0; bus.cp0_wdata = '0;
      bus.redirect_ack = 0;
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      bus.cp0_we = 1; bus.cp0_waddr = addr; bus.cp0_wdata = data;
      tick();
      bus.cp0_we = 0;
   endtask

   task automatic ack_redirect();
      bus.ex_valid = 0; bus.ex_overflow = 0; bus.ex_eret = 0;
      bus.redirect_ack = 1;
      tick();
      bus.redirect_ack = 0;
   endtask

   int rv_cycles, fl_cycles;

   initial begin
      idle_inputs();
      bus.cp0_raddr = 5'd12;
      model_reset();

      // Reset state
      #3;
      check_outputs("_rst");
      check_regs();
      @(negedge clk);
      rst_n = 1;
      tick();

      // Overflow from EXL=0
      bus.ex_valid = 1; bus.ex_overflow = 1; bus.ex_pc = 32'h40;
      tick();
      check("ov_flush", {31'b0, bus.flush}, 32'd1);
      check("ov_rpc", bus.redirect_pc, 32'h8);
      check("ov_in_handler", {31'b0, bus.in_handler}, 32'd1);
      check_reg_const("ov_epc", 5'd14, 32'h40);
      check_reg_const("ov_cause", 5'd13, 32'd12 << 2);
      ack_redirect();
      check_regs();

      // Interrupt enabled through MTC0 Status
      mtc0(5'd12, 32'h0000_0401);
      bus.ext_int = 6'b000001; bus.ex_valid = 1; bus.ex_pc = 32'h80;
      tick();
      check("int_flush", {31'b0, bus.flush}, 32'd1);
      check_reg_const("int_epc", 5'd14, 32'h80);
      check_reg_const("int_cause", 5'd13, 32'h0000_0400);
      bus.ext_int = '0;
      ack_redirect();

      // ERET with EXL=1 returns to EPC
      mtc0(5'd14, 32'h40);
      bus.ex_valid = 1; bus.ex_eret = 1; bus.ex_pc = 32'h90;
      tick();
      check("eret_rpc", bus.redirect_pc, 32'h40);
      check("eret_in_handler", {31'b0, bus.in_handler}, 32'd0);
      ack_redirect();

      // ERET with EXL=0 is ignored
      bus.ex_valid = 1; bus.ex_eret = 1;
      tick();
      check("eret_noexl_flush", {31'b0, bus.flush}, 32'd0);
      bus.ex_eret = 0; bus.ex_valid = 0;

      // Interrupt masked by IE=0
      mtc0(5'd12, 32'h0000_0400);
      bus.ext_int = 6'b000001; bus.ex_valid = 1; bus.ex_pc = 32'h80;
      tick();
      check("ie0_flush", {31'b0, bus.flush}, 32'd0);
      bus.ext_int = '0; bus.ex_valid = 0;

      // Slow acknowledge; overflow held active throughout is ignored
      rv_cycles = 0; fl_cycles = 0;
      bus.ex_valid = 1; bus.ex_overflow = 1; bus.ex_pc = 32'h60;
      tick();
      rv_cycles += int'(bus.redirect_valid); fl_cycles += int'(bus.flush);
      for (int i = 0; i < 3; i++) begin
         bus.ex_pc = 32'h200 + 32'(i);
         tick();
         rv_cycles += int'(bus.redirect_valid); fl_cycles += int'(bus.flush);
      end
      ack_redirect();
      rv_cycles += int'(bus.redirect_valid);
      check("slow_rv_cycles", 32'(rv_cycles), 32'd4);
      check("slow_flush_cycles", 32'(fl_cycles), 32'd1);
      check_reg_const("slow_epc", 5'd14, 32'h60);

      // Nested overflow keeps EPC; coincident MTC0 to EPC is dropped
      bus.ex_valid = 1; bus.ex_overflow = 1; bus.ex_pc = 32'h100;
      bus.cp0_we = 1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hdead_beef;
      tick();
      bus.cp0_we = 0;
      check("nest_flush", {31'b0, bus.flush}, 32'd1);
      check_reg_const("nest_epc", 5'd14, 32'h60);
      check_reg_const("nest_cause", 5'd13, 32'd12 << 2);
      ack_redirect();

      // Reset in the middle of a redirect
      mtc0(5'd12, 32'h0);
      bus.ex_valid = 1; bus.ex_overflow = 1; bus.ex_pc = 32'h44;
      tick();
      idle_inputs();
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_outputs("_midrst");
      check_regs();
      @(negedge clk);
      rst_n = 1;
      tick();
      tick();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         bus.ex_valid     = 1'($urandom_range(0, 1));
         bus.ex_pc        = $urandom & 32'hffff_fffc;
         bus.ex_overflow  = ($urandom_range(0, 7) == 0);
         bus.ex_eret      = ($urandom_range(0, 3) == 0);
         bus.ext_int      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         bus.cp0_we       = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       bus.cp0_waddr = 5'd12;
            1:       bus.cp0_waddr = 5'd13;
            2:       bus.cp0_waddr = 5'd14;
            default: bus.cp0_waddr = 5'($urandom);
         endcase
         bus.cp0_wdata    = $urandom;
         bus.redirect_ack = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       bus.cp0_raddr = 5'd12;
            1:       bus.cp0_raddr = 5'd13;
            2:       bus.cp0_raddr = 5'd14;
            default: bus.cp0_raddr = 5'($urandom);
         endcase
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
